sargantana_icache_mem_array: RTL and testbench
==============================================

SARGANTANA_ICACHE_MEM_ARRAY -- requirements
Module: sargantana_icache_mem_array

Interface
REQ-001 SHALL have parameter N_WAY, default 4, number of ways.
REQ-002 SHALL have parameter N_SETS, default 128, sets per way; power of two, at least 2; IDX_W = clog2(N_SETS).
REQ-003 SHALL have parameter LINE_W, default 256, cache-line bits.
REQ-004 SHALL have parameter TAG_W, default 44, tag bits.
REQ-005 SHALL use one clock; reset is synchronous and active-high.
REQ-006 SHALL have port clk_i  input  1  clock; all state updates on rising edge.
REQ-007 SHALL have port rst_i  input  1  synchronous active-high reset.
REQ-008 SHALL have port flush_i  input  1  one-cycle pulse requesting invalidate-all.
REQ-009 SHALL have port req_valid_i  input  1  request valid.
REQ-010 SHALL have port req_ready_o  output  1  request accepted this cycle when high with req_valid_i.
REQ-011 SHALL have port way_req_i  input  N_WAY  per-way enable mask.
REQ-012 SHALL have port we_i  input  1  1 = write, 0 = read.
REQ-013 SHALL have port valid_bit_i, tag_i, cline_i  input  1 / TAG_W / LINE_W  write data.
REQ-014 SHALL have port addr_i  input  IDX_W  set index.
REQ-015 SHALL have port rsp_valid_o  output  1  read data valid.
REQ-016 SHALL have ports valid_bit_o, tag_way_o, cline_way_o  output  N_WAY / N_WAY x TAG_W / N_WAY x LINE_W  per-way read data.
REQ-017 SHALL have port busy_o  output  1  flush sweep in progress.

Function
REQ-018 SHALL implement a two-state FSM: IDLE and FLUSH.
REQ-019 SHALL drive req_ready_o = 1 only in IDLE with flush_i low; busy_o = 1 exactly in FLUSH.
REQ-020 In FLUSH, SHALL clear the valid bit of all ways at set counter cnt each cycle; cnt counts 0 to N_SETS-1.
REQ-021 SHALL return to IDLE in the cycle after cnt = N_SETS-1 is cleared; a sweep takes exactly N_SETS cycles.
REQ-022 flush_i in IDLE SHALL enter FLUSH next cycle with cnt = 0; a request presented in the same cycle SHALL be dropped, because req_ready_o = 0.
REQ-023 flush_i during FLUSH SHALL be ignored; the sweep does not restart.
REQ-024 An accepted write SHALL update valid, tag and line at addr_i in every way whose way_req_i bit is 1 and leave the other ways unchanged; way_req_i = 0 SHALL be a no-op.
REQ-025 An accepted read SHALL assert rsp_valid_o for exactly one cycle, one cycle later, with data at addr_i for every way.
REQ-026 On that response, ways with way_req_i = 0 SHALL output all-zero valid, tag and line.
REQ-027 A read accepted in the cycle after a write to the same set SHALL return the newly written data.
REQ-028 Writes SHALL never assert rsp_valid_o.
REQ-029 While rsp_valid_o = 0, the data outputs SHALL hold their last values.
REQ-030 Tag and line storage SHALL NOT be reset or altered by the flush sweep.

Reset
REQ-031 Reset SHALL force FSM = FLUSH, cnt = 0, rsp_valid_o = 0, all data outputs = 0, req_ready_o = 0 and busy_o = 1 from the following cycle.
REQ-032 After reset deasserts, the block SHALL sweep N_SETS cycles and then enter IDLE with all valid bits 0.
REQ-033 Reset asserted mid-sweep or mid-read SHALL restart the sweep from cnt = 0 and drop any pending response.

Structure
REQ-034 Package sargantana_icache_pkg SHALL hold the default N_WAY, N_SETS, LINE_W and TAG_W and the typedefs for the FSM state, tag and line.
REQ-035 Sub-module sargantana_icache_way_ram SHALL be one way's storage: valid, tag and line arrays, synchronous one-port read/write, and a separate valid-clear port.
REQ-036 The top level SHALL instantiate N_WAY copies of sargantana_icache_way_ram by generate, plus the FSM and response register.

Verification
REQ-037 Reset for 2 cycles, then release -> busy_o = 1 for exactly 128 cycles, req_ready_o = 0 throughout; then read set 5 with mask 4'b1111 -> valid_bit_o = 4'b0000.
REQ-038 Write way 0, set 6, tag 44'h24, line 256'h12345; next cycle read set 6 mask 4'b0001 -> one cycle later rsp_valid_o = 1, valid_bit_o = 4'b0001, tag_way_o[0] = 44'h24, cline_way_o[0] = 256'h12345.
REQ-039 Write way 1, set 20 (tag 44'h67); read set 20 mask 4'b0011 -> way 1 data returned, way 0 valid = 0; same read with mask 4'b0001 -> way 1 outputs all-zero.
REQ-040 After REQ-038, pulse flush_i together with req_valid_i -> request dropped, 128 busy cycles; then read set 6 -> valid 0 while tag_way_o[0] is still 44'h24.
REQ-041 Pulse flush_i again at sweep cycle 50 -> sweep still ends at cycle 128; assert rst_i at sweep cycle 60 -> a fresh 128-cycle sweep starts.
REQ-042 Back-to-back reads of sets 3 and 4 -> two consecutive rsp_valid_o cycles in order; outputs hold afterwards.

Source files
------------

// File: rtl/sargantana_icache_pkg.sv
// sargantana_icache_pkg
// Shared definitions for the instruction-cache memory array:
//   - default geometry (ways, sets, line and tag widths)
//   - FSM state type with its two legal values
//   - tag and line typedefs sized to the default geometry
package sargantana_icache_pkg;

  localparam int unsigned ICACHE_N_WAY  = 4;
  localparam int unsigned ICACHE_N_SETS = 128;
  localparam int unsigned ICACHE_LINE_W = 256;
  localparam int unsigned ICACHE_TAG_W  = 44;

  typedef logic [0:0] icache_state_t;

  localparam icache_state_t ST_IDLE  = 1'b0;
  localparam icache_state_t ST_FLUSH = 1'b1;

  typedef logic [ICACHE_TAG_W-1:0]  icache_tag_t;
  typedef logic [ICACHE_LINE_W-1:0] icache_line_t;

endpackage

// File: rtl/sargantana_icache_way_ram.sv
// sargantana_icache_way_ram
// Storage for a single cache way: valid bit, tag and line per set.
// Ports:
//   clk_i, rst_i           clock, synchronous active-high reset (output register only)
//   en_i                   this way takes part in the current accepted access
//   rd_i                   an accepted read is happening (all ways update their output)
//   we_i                   1 = write, 0 = read
//   addr_i                 set index of the access
//   valid_bit_i/tag_i/cline_i  write data
//   clr_i, clr_addr_i      independent valid-clear port used by the flush sweep
//   valid_bit_o/tag_o/cline_o  registered read data
module sargantana_icache_way_ram
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N_SETS = ICACHE_N_SETS,
  parameter int unsigned LINE_W = ICACHE_LINE_W,
  parameter int unsigned TAG_W  = ICACHE_TAG_W,
  localparam int unsigned IDX_W = $clog2(N_SETS)
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              en_i,
  input  logic              rd_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  addr_i,
  input  logic              valid_bit_i,
  input  logic [TAG_W-1:0]  tag_i,
  input  logic [LINE_W-1:0] cline_i,
  input  logic              clr_i,
  input  logic [IDX_W-1:0]  clr_addr_i,
  output logic              valid_bit_o,
  output logic [TAG_W-1:0]  tag_o,
  output logic [LINE_W-1:0] cline_o
);

  logic [N_SETS-1:0] valid_q;
  logic [TAG_W-1:0]  tag_q  [N_SETS];
  logic [LINE_W-1:0] line_q [N_SETS];

  // Tag and line storage is never reset so it can map onto plain SRAM.
  always_ff @(posedge clk_i) begin
    if (en_i && we_i) begin
      tag_q[addr_i]  <= tag_i;
      line_q[addr_i] <= cline_i;
    end
  end

  // The clear port and the write port are never active together because
  // writes are only accepted outside the flush sweep.
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      valid_q[clr_addr_i] <= 1'b0;
    end else if (en_i && we_i) begin
      valid_q[addr_i] <= valid_bit_i;
    end
  end

  // Every accepted read reloads the output register: requested ways get the
  // stored entry, unrequested ways are forced to zero. Otherwise it holds.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      valid_bit_o <= 1'b0;
      tag_o       <= '0;
      cline_o     <= '0;
    end else if (rd_i) begin
      if (en_i) begin
        valid_bit_o <= valid_q[addr_i];
        tag_o       <= tag_q[addr_i];
        cline_o     <= line_q[addr_i];
      end else begin
        valid_bit_o <= 1'b0;
        tag_o       <= '0;
        cline_o     <= '0;
      end
    end
  end

endmodule

// File: rtl/sargantana_icache_mem_array.sv
// sargantana_icache_mem_array
// N_WAY-way instruction-cache data/tag array with a flush sweep.
// Ports:
//   clk_i, rst_i         clock, synchronous active-high reset
//   flush_i              one-cycle invalidate-all request
//   req_valid_i/req_ready_o  request handshake
//   way_req_i            per-way enable mask
//   we_i                 1 = write, 0 = read
//   valid_bit_i, tag_i, cline_i  write data
//   addr_i               set index
//   rsp_valid_o          one-cycle read response strobe
//   valid_bit_o, tag_way_o, cline_way_o  per-way read data (held between responses)
//   busy_o               flush sweep in progress
module sargantana_icache_mem_array
  import sargantana_icache_pkg::*;
#(
  parameter int unsigned N_WAY  = ICACHE_N_WAY,
  parameter int unsigned N_SETS = ICACHE_N_SETS,
  parameter int unsigned LINE_W = ICACHE_LINE_W,
  parameter int unsigned TAG_W  = ICACHE_TAG_W,
  localparam int unsigned IDX_W = $clog2(N_SETS)
) (
  input  logic                         clk_i,
  input  logic                         rst_i,
  input  logic                         flush_i,
  input  logic                         req_valid_i,
  output logic                         req_ready_o,
  input  logic [N_WAY-1:0]             way_req_i,
  input  logic                         we_i,
  input  logic                         valid_bit_i,
  input  logic [TAG_W-1:0]             tag_i,
  input  logic [LINE_W-1:0]            cline_i,
  input  logic [IDX_W-1:0]             addr_i,
  output logic                         rsp_valid_o,
  output logic [N_WAY-1:0]             valid_bit_o,
  output logic [N_WAY-1:0][TAG_W-1:0]  tag_way_o,
  output logic [N_WAY-1:0][LINE_W-1:0] cline_way_o,
  output logic                         busy_o
);

  icache_state_t    state_q;
  logic [IDX_W-1:0] cnt_q;
  logic             accept;
  logic             sweep_clr;

  // A flush request in the same cycle wins over any request, so ready drops.
  assign req_ready_o = (state_q == ST_IDLE) && !flush_i;
  assign busy_o      = (state_q == ST_FLUSH);
  assign accept      = req_valid_i && req_ready_o;
  assign sweep_clr   = (state_q == ST_FLUSH);

  // Reset lands in FLUSH so the valid bits are always swept clean before use.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= ST_FLUSH;
      cnt_q       <= '0;
      rsp_valid_o <= 1'b0;
    end else begin
      rsp_valid_o <= accept && !we_i;
      case (state_q)
        ST_IDLE: begin
          if (flush_i) begin
            state_q <= ST_FLUSH;
            cnt_q   <= '0;
          end
        end
        default: begin
          cnt_q <= cnt_q + IDX_W'(1);
          if (cnt_q == IDX_W'(N_SETS - 1)) begin
            state_q <= ST_IDLE;
          end
        end
      endcase
    end
  end

  for (genvar w = 0; w < N_WAY; w++) begin : g_way
    sargantana_icache_way_ram #(
      .N_SETS (N_SETS),
      .LINE_W (LINE_W),
      .TAG_W  (TAG_W)
    ) u_way_ram (
      .clk_i       (clk_i),
      .rst_i       (rst_i),
      .en_i        (accept && way_req_i[w]),
      .rd_i        (accept && !we_i),
      .we_i        (we_i),
      .addr_i      (addr_i),
      .valid_bit_i (valid_bit_i),
      .tag_i       (tag_i),
      .cline_i     (cline_i),
      .clr_i       (sweep_clr),
      .clr_addr_i  (cnt_q),
      .valid_bit_o (valid_bit_o[w]),
      .tag_o       (tag_way_o[w]),
      .cline_o     (cline_way_o[w])
    );
  end

endmodule

// File: tb/tb_sargantana_icache_mem_array.sv
// tb_sargantana_icache_mem_array
// Self-checking bench: directed scenarios plus random traffic, every cycle
// compared against a set-level behavioural model of the cache array.
module tb_sargantana_icache_mem_array;

  localparam int N_WAY  = 4;
  localparam int N_SETS = 128;
  localparam int LINE_W = 256;
  localparam int TAG_W  = 44;
  localparam int IDX_W  = 7;

  logic clk;
  logic rst, flush, req_valid, we, vbit;
  logic req_ready, rsp_valid, busy;
  logic [N_WAY-1:0] way_req, valid_bit_o;
  logic [TAG_W-1:0] tag;
  logic [LINE_W-1:0] cline;
  logic [IDX_W-1:0] addr;
  logic [N_WAY-1:0][TAG_W-1:0] tag_way;
  logic [N_WAY-1:0][LINE_W-1:0] cline_way;

  int checks = 0;
  int errors = 0;

  // Reference model: storage contents, remaining sweep length, expected outputs
  bit                m_valid [N_WAY][N_SETS];
  logic [TAG_W-1:0]  m_tag   [N_WAY][N_SETS];
  logic [LINE_W-1:0] m_line  [N_WAY][N_SETS];
  bit                m_known [N_WAY][N_SETS];
  int                sweep_left = 0;
  bit                e_rsp = 0;
  logic [N_WAY-1:0]  e_valid = '0;
  logic [TAG_W-1:0]  e_tag   [N_WAY];
  logic [LINE_W-1:0] e_line  [N_WAY];
  bit                e_known [N_WAY];

  sargantana_icache_mem_array dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .flush_i     (flush),
    .req_valid_i (req_valid),
    .req_ready_o (req_ready),
    .way_req_i   (way_req),
    .we_i        (we),
    .valid_bit_i (vbit),
    .tag_i       (tag),
    .cline_i     (cline),
    .addr_i      (addr),
    .rsp_valid_o (rsp_valid),
    .valid_bit_o (valid_bit_o),
    .tag_way_o   (tag_way),
    .cline_way_o (cline_way),
    .busy_o      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the clock edge,
  // then compare every output 1 time unit after the edge.
  task automatic applyStimulus(input logic r, input logic f, input logic v, input logic w,
                               input logic [N_WAY-1:0] m, input logic [IDX_W-1:0] a,
                               input logic vb, input logic [TAG_W-1:0] t,
                               input logic [LINE_W-1:0] l);
    bit was_busy;
    rst = r; flush = f; req_valid = v; we = w; way_req = m;
    addr = a; vbit = vb; tag = t; cline = l;
    @(posedge clk);
    was_busy = (sweep_left > 0);
    e_rsp = 1'b0;
    if (r) begin
      sweep_left = N_SETS;
      e_valid = '0;
      for (int k = 0; k < N_WAY; k++) begin
        e_tag[k] = '0; e_line[k] = '0; e_known[k] = 1'b1;
      end
    end else if (was_busy) begin
      for (int k = 0; k < N_WAY; k++) m_valid[k][N_SETS - sweep_left] = 1'b0;
      sweep_left--;
    end else if (f) begin
      sweep_left = N_SETS;
    end else if (v && w) begin
      for (int k = 0; k < N_WAY; k++) begin
        if (m[k]) begin
          m_valid[k][a] = vb; m_tag[k][a] = t; m_line[k][a] = l; m_known[k][a] = 1'b1;
        end
      end
    end else if (v) begin
      e_rsp = 1'b1;
      for (int k = 0; k < N_WAY; k++) begin
        if (m[k]) begin
          e_valid[k] = m_valid[k][a]; e_tag[k] = m_tag[k][a];
          e_line[k] = m_line[k][a]; e_known[k] = m_known[k][a];
        end else begin
          e_valid[k] = 1'b0; e_tag[k] = '0; e_line[k] = '0; e_known[k] = 1'b1;
        end
      end
    end
    #1;
    checkOutput("busy", 256'(busy), 256'(sweep_left > 0));
    checkOutput("ready", 256'(req_ready), 256'((sweep_left == 0) && !f));
    checkOutput("rsp_valid", 256'(rsp_valid), 256'(e_rsp));
    checkOutput("valid_bits", 256'(valid_bit_o), 256'(e_valid));
    for (int k = 0; k < N_WAY; k++) begin
      if (e_known[k]) begin
        checkOutput($sformatf("tag_w%0d", k), 256'(tag_way[k]), 256'(e_tag[k]));
        checkOutput($sformatf("line_w%0d", k), cline_way[k], e_line[k]);
      end
    end
  endtask

  task automatic idleCycle();
    applyStimulus(0, 0, 0, 0, '0, '0, 0, '0, '0);
  endtask

  task automatic readSet(input logic [IDX_W-1:0] a, input logic [N_WAY-1:0] m);
    applyStimulus(0, 0, 1, 0, m, a, 0, '0, '0);
  endtask

  task automatic writeSet(input logic [IDX_W-1:0] a, input logic [N_WAY-1:0] m,
                          input logic [TAG_W-1:0] t, input logic [LINE_W-1:0] l);
    applyStimulus(0, 0, 1, 1, m, a, 1, t, l);
  endtask

  // Counts consecutive busy samples, including the one already on the outputs.
  task automatic countSweep(output int n);
    int guard;
    n = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 400) begin
      guard++;
      idleCycle();
      if (busy) n++;
    end
  endtask

  int n;
  int guard;
  int r;
  logic [LINE_W-1:0] rline;

  initial begin
    for (int k = 0; k < N_WAY; k++) begin
      e_tag[k] = '0; e_line[k] = '0; e_known[k] = 1'b0;
      for (int s = 0; s < N_SETS; s++) begin
        m_valid[k][s] = 1'b0; m_known[k][s] = 1'b0;
        m_tag[k][s] = '0; m_line[k][s] = '0;
      end
    end

    // Reset for two cycles, then a full sweep with requests being refused
    applyStimulus(1, 0, 0, 0, '0, '0, 0, '0, '0);
    applyStimulus(1, 0, 0, 0, '0, '0, 0, '0, '0);
    n = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 400) begin
      guard++;
      readSet(IDX_W'($urandom_range(0, N_SETS - 1)), 4'b1111);
      if (busy) n++;
    end
    checkOutput("reset_sweep_len", 256'(n), 256'(N_SETS));

    readSet(7'd5, 4'b1111);
    checkOutput("set5_valid", 256'(valid_bit_o), 256'(4'b0000));
    idleCycle();

    // Write then immediately read back
    writeSet(7'd6, 4'b0001, 44'h24, 256'h12345);
    readSet(7'd6, 4'b0001);
    checkOutput("set6_rsp", 256'(rsp_valid), 256'(1));
    checkOutput("set6_valid", 256'(valid_bit_o), 256'(4'b0001));
    checkOutput("set6_tag", 256'(tag_way[0]), 256'(44'h24));
    checkOutput("set6_line", cline_way[0], 256'h12345);
    idleCycle();

    // Way masking on reads
    writeSet(7'd20, 4'b0010, 44'h67, 256'hABCDEF);
    readSet(7'd20, 4'b0011);
    checkOutput("set20_valid", 256'(valid_bit_o), 256'(4'b0010));
    checkOutput("set20_tag1", 256'(tag_way[1]), 256'(44'h67));
    readSet(7'd20, 4'b0001);
    checkOutput("set20_w1_valid", 256'(valid_bit_o[1]), 256'(0));
    checkOutput("set20_w1_tag", 256'(tag_way[1]), 256'(0));
    checkOutput("set20_w1_line", cline_way[1], 256'(0));

    // Flush together with a request: request dropped, valid cleared, tag kept
    applyStimulus(0, 1, 1, 0, 4'b0001, 7'd6, 0, '0, '0);
    checkOutput("flush_drop_rsp", 256'(rsp_valid), 256'(0));
    countSweep(n);
    checkOutput("flush_sweep_len", 256'(n), 256'(N_SETS));
    readSet(7'd6, 4'b0001);
    checkOutput("post_flush_valid", 256'(valid_bit_o), 256'(4'b0000));
    checkOutput("post_flush_tag", 256'(tag_way[0]), 256'(44'h24));

    // Second flush mid-sweep is ignored
    applyStimulus(0, 1, 0, 0, '0, '0, 0, '0, '0);
    n = busy ? 1 : 0;
    guard = 0;
    while (busy && guard < 400) begin
      guard++;
      if (n == 50) applyStimulus(0, 1, 0, 0, '0, '0, 0, '0, '0);
      else idleCycle();
      if (busy) n++;
    end
    checkOutput("reflush_sweep_len", 256'(n), 256'(N_SETS));

    // Reset mid-sweep restarts a full sweep
    applyStimulus(0, 1, 0, 0, '0, '0, 0, '0, '0);
    for (int i = 1; i < 60; i++) idleCycle();
    applyStimulus(1, 0, 0, 0, '0, '0, 0, '0, '0);
    countSweep(n);
    checkOutput("reset_mid_sweep_len", 256'(n), 256'(N_SETS));

    // Back-to-back reads, then outputs hold
    writeSet(7'd3, 4'b1111, 44'h333, 256'h3333);
    writeSet(7'd4, 4'b0101, 44'h444, 256'h4444);
    readSet(7'd3, 4'b1111);
    checkOutput("b2b_rsp3", 256'(rsp_valid), 256'(1));
    readSet(7'd4, 4'b1111);
    checkOutput("b2b_rsp4", 256'(rsp_valid), 256'(1));
    checkOutput("b2b_valid4", 256'(valid_bit_o), 256'(4'b0101));
    idleCycle();
    idleCycle();
    checkOutput("hold_tag2", 256'(tag_way[2]), 256'(44'h444));

    // Random traffic over a small set range so reads hit earlier writes
    for (int i = 0; i < 700; i++) begin
      r = int'($urandom_range(0, 999));
      rline = {$urandom(), $urandom(), $urandom(), $urandom(),
               $urandom(), $urandom(), $urandom(), $urandom()};
      if (r < 3) begin
        applyStimulus(1, 0, 0, 0, '0, '0, 0, '0, '0);
      end else if (r < 12) begin
        applyStimulus(0, 1, 1'($urandom_range(0, 1)), 0, 4'($urandom), 7'($urandom_range(0, 15)),
                      0, '0, '0);
      end else begin
        applyStimulus(0, 0, 1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)),
                      4'($urandom), 7'($urandom_range(0, 15)), 1'($urandom_range(0, 1)),
                      {12'($urandom), $urandom()}, rline);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
